key_schedule_multi: RTL and testbench
=====================================

# key_schedule_multi

Key expansion unit generalising the fixed AES-128 decryption key generator to AES-128/192/256, selectable per operation. It expands a cipher key into the full FIPS-197 word schedule, one 32-bit word per clock, and stores it in an internal register file. A registered read port serves the round-key bus of the encryption and decryption pipelines. The block sits between the control FSM, which supplies the key and start, and the round datapaths.

## Interface

Parameters:
- `MAX_NK`, default 8: largest supported key length in 32-bit words (4, 6 or 8).
  - Key port width is `32*MAX_NK`.
  - Word storage depth is `4*(MAX_NK+7)`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin an expansion.
- `key_size`  in  2  key length select.
  - 00 = AES-128 (Nk=4, Nr=10)
  - 01 = AES-192 (Nk=6, Nr=12)
  - 10 = AES-256 (Nk=8, Nr=14)
  - 11 = invalid
- `key`  in  32*MAX_NK  cipher key; w0 is the top word `key[32*MAX_NK-1 -: 32]`. Shorter keys are left-aligned and the low bits are ignored.
- `rd_round`  in  4  round-key index to read.
- `rd_dec`  in  1  decryption-order read. Present only with `KEYSCHED_DEC_ORDER_EN`.
- `busy`  out  1  expansion in progress.
- `ready`  out  1  schedule complete and readable.
- `rd_key`  out  128  registered round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}.

## Operation

State machine:
- States: IDLE, EXPAND, READY.
- Reset clears all three outputs and puts the block in IDLE.
- **Request accepted:** `start` is high in IDLE or READY, `key_size` is valid, and its Nk does not exceed `MAX_NK`.
  - Latch Nk, Nr and T = 4*(Nr+1) (44/52/60).
  - Write w[0..Nk-1] from `key`; word counter i = Nk; rcon = 0x01.
  - Go to EXPAND.
- **Request rejected:** `start` with an invalid or unsupported size, or `start` during EXPAND, is ignored. State, storage and outputs are unchanged.
- **EXPAND**, one word per cycle:
  - temp = w[i-1].
  - If i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then rcon = xtime(rcon).
  - Else if Nk == 8 and i mod 8 == 4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp; i increments.
  - SubWord uses the shared S-box.
- **Completion:** on the edge that writes w[T-1], go to READY.
- **Restart from READY:** accepted; `ready` drops on the next edge and the schedule is rebuilt.
- Stored words beyond T are not cleared and are never returned.

Read port:
- Each clock, effective round r = `rd_round`.
- `rd_key` <= {w[4r..4r+3]} when `ready` is high and r ≤ Nr; otherwise `rd_key` <= 0.
- The index is sampled in every state. While not ready the output is forced to 0.

## Timing

- `busy` = (state == EXPAND); `ready` = (state == READY). Both are registered state decodes.
- With `start` sampled at edge E0:
  - `busy` rises after E0.
  - The last word is written at edge E0+1+(T-Nk).
  - `ready` rises and `busy` falls after that edge.
- Start-to-ready latency: 41 cycles (AES-128), 47 (AES-192), 53 (AES-256).
- Read latency is 1 cycle: `rd_round` sampled at edge En appears on `rd_key` after En.
- A read issued on the edge where `ready` rises returns 0. The first valid read is sampled with `ready` already high.
- Reset asserted mid-expansion aborts immediately. Outputs return to 0, and a new `start` is required.

## Configuration

- `KEYSCHED_DEC_ORDER_EN` defined:
  - Adds the `rd_dec` port.
  - When `rd_dec` = 1, effective r = Nr - `rd_round`, so index 0 returns the last round key, for the decryption pipeline.
  - If `rd_round` > Nr, the output is 0.
- Not defined: no `rd_dec` port, and r = `rd_round` always.

## Test plan

- **AES-128 vector:** key 2b7e151628aed2a6abf7158809cf4f3c, start → `ready` high after 41 cycles; `rd_round`=10 → `rd_key` d014f9a8c9ee2589e13f0cc8b6630ca6; `rd_round`=0 → the key itself.
- **AES-192 vector:** key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → `ready` after 47 cycles; `rd_round`=12 → e98ba06f448c773c8ecc720401002202; `rd_round`=13 → 0.
- **AES-256 vector:** key 603deb10...0914dff4 → `ready` after 53 cycles; `rd_round`=14 → fe4890d1e6188d0b046df344706c631e; with `KEYSCHED_DEC_ORDER_EN` and `rd_dec`=1, `rd_round`=0 → same value.
- **Rejection:**
  - `key_size`=11 with `start` in IDLE → `busy` stays 0.
  - `start` during EXPAND → latency and the final key are unchanged.
  - With `MAX_NK`=4, `key_size`=10 → ignored.
- **Reset mid-expansion:** assert `rst` low 20 cycles after start → `busy`, `ready` and `rd_key` go to 0 immediately. Restart with AES-128 → correct keys after 41 cycles.
- **Restart from READY:** AES-256 is complete; start AES-128 → `ready` drops one cycle later, returns after 41 cycles, and round 10 matches the AES-128 vector.

Source files
------------

// File: rtl/key_schedule_multi.sv
// key_schedule_multi: AES-128/192/256 key expansion, one word per clock,
// with a registered round-key read port. Define KEYSCHED_DEC_ORDER_EN for rd_dec.
module key_schedule_multi #(
    parameter int MAX_NK = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           key_size,
    input  logic [32*MAX_NK-1:0] key,
    input  logic [3:0]           rd_round,
`ifdef KEYSCHED_DEC_ORDER_EN
    input  logic                 rd_dec,
`endif
    output logic                 busy,
    output logic                 ready,
    output logic [127:0]         rd_key
);

    localparam int DEPTH = 4 * (MAX_NK + 7);

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        READY
    } state_t;

    state_t      state;
    logic [31:0] w_mem [DEPTH];
    logic [3:0]  nk;
    logic [3:0]  nr;
    logic [5:0]  t_len;
    logic [5:0]  idx;
    logic [2:0]  phase;
    logic [7:0]  rcon;
    logic        prime;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240;
        logic [7:0] inv;
        a2   = gf_mul(a, a);
        a3   = gf_mul(a2, a);
        a6   = gf_mul(a3, a3);
        a12  = gf_mul(a6, a6);
        a15  = gf_mul(a12, a3);
        a30  = gf_mul(a15, a15);
        a60  = gf_mul(a30, a30);
        a120 = gf_mul(a60, a60);
        a240 = gf_mul(a120, a120);
        inv  = gf_mul(gf_mul(a240, a12), a2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    logic [3:0] req_nk;
    logic [3:0] req_nr;
    logic       req_ok;
    logic       accept;

    // Decode the requested key size and whether this build supports it
    always_comb begin
        req_nk = 4'd4;
        req_nr = 4'd10;
        req_ok = 1'b0;
        unique case (key_size)
            2'b00: begin
                req_nk = 4'd4;
                req_nr = 4'd10;
                req_ok = 1'b1;
            end
            2'b01: begin
                req_nk = 4'd6;
                req_nr = 4'd12;
                req_ok = (MAX_NK >= 6);
            end
            2'b10: begin
                req_nk = 4'd8;
                req_nr = 4'd14;
                req_ok = (MAX_NK >= 8);
            end
            default: req_ok = 1'b0;
        endcase
    end

    assign accept = start && req_ok && (state != EXPAND);

    logic [31:0] prev;
    logic [31:0] back;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] temp;
    logic [31:0] new_word;

    // Next schedule word; one shared SubWord serves both rotate and Nk=8 cases
    always_comb begin
        prev     = w_mem[idx - 6'd1];
        back     = w_mem[idx - {2'b00, nk}];
        sub_in   = (phase == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
        sub_out  = sub_word(sub_in);
        temp     = prev;
        if (phase == 3'd0)
            temp = sub_out ^ {rcon, 24'h000000};
        else if (nk == 4'd8 && phase == 3'd4)
            temp = sub_out;
        new_word = back ^ temp;
    end

    // Control FSM; first EXPAND cycle lets the newly loaded key words settle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            ready <= 1'b0;
            nk    <= 4'd4;
            nr    <= 4'd10;
            t_len <= 6'd44;
            idx   <= 6'd0;
            phase <= 3'd0;
            rcon  <= 8'h01;
            prime <= 1'b0;
        end else if (accept) begin
            state <= EXPAND;
            busy  <= 1'b1;
            ready <= 1'b0;
            nk    <= req_nk;
            nr    <= req_nr;
            t_len <= {req_nr, 2'b00} + 6'd4;
            idx   <= {2'b00, req_nk};
            phase <= 3'd0;
            rcon  <= 8'h01;
            prime <= 1'b1;
        end else if (state == EXPAND) begin
            if (prime) begin
                prime <= 1'b0;
            end else begin
                idx   <= idx + 6'd1;
                phase <= ({1'b0, phase} == nk - 4'd1) ? 3'd0 : phase + 3'd1;
                if (phase == 3'd0) rcon <= xtime(rcon);
                if (idx == t_len - 6'd1) begin
                    state <= READY;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end
            end
        end
    end

    // Word storage: key words on accept, one expanded word per EXPAND cycle
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int j = 0; j < MAX_NK; j++) begin
                if (j < int'(req_nk))
                    w_mem[j] <= key[32*(MAX_NK-j)-1 -: 32];
            end
        end else if (state == EXPAND && !prime) begin
            w_mem[idx] <= new_word;
        end
    end

    logic [3:0] eff_r;
    logic       rd_ok;
    logic [5:0] base;

    // Effective round index and read qualification
    always_comb begin
        eff_r = rd_round;
`ifdef KEYSCHED_DEC_ORDER_EN
        if (rd_dec) eff_r = nr - rd_round;
`endif
        rd_ok = (state == READY) && (rd_round <= nr);
        base  = rd_ok ? {eff_r, 2'b00} : 6'd0;
    end

    // Registered round-key read port, zero unless a valid schedule is read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_key <= '0;
        end else if (rd_ok) begin
            rd_key <= {w_mem[base], w_mem[base + 6'd1],
                       w_mem[base + 6'd2], w_mem[base + 6'd3]};
        end else begin
            rd_key <= '0;
        end
    end

endmodule

// File: tb/tb_key_schedule_multi.sv
// tb_key_schedule_multi: scoreboard bench for key_schedule_multi with a
// FIPS-197 reference schedule built from a log/antilog generated S-box.
`timescale 1ns/1ps
module tb_key_schedule_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start;
    logic [1:0]   key_size;
    logic [255:0] key;
    logic [3:0]   rd_round;
`ifdef KEYSCHED_DEC_ORDER_EN
    logic         rd_dec;
`endif
    logic         busy;
    logic         ready;
    logic [127:0] rd_key;

    logic         start4;
    logic [1:0]   ks4;
    logic [127:0] key4;
    logic [3:0]   rr4;
    logic         busy4;
    logic         ready4;
    logic [127:0] rk4;

    key_schedule_multi #(.MAX_NK(8)) dut (
        .clk(clk), .rst(rst), .start(start), .key_size(key_size),
        .key(key), .rd_round(rd_round),
`ifdef KEYSCHED_DEC_ORDER_EN
        .rd_dec(rd_dec),
`endif
        .busy(busy), .ready(ready), .rd_key(rd_key)
    );

    key_schedule_multi #(.MAX_NK(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .key_size(ks4),
        .key(key4), .rd_round(rr4),
`ifdef KEYSCHED_DEC_ORDER_EN
        .rd_dec(1'b0),
`endif
        .busy(busy4), .ready(ready4), .rd_key(rk4)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model
    logic [7:0]  sb [256];
    logic [7:0]  rcon_tab [10];
    logic [31:0] ref_w [60];
    int          ref_nr;

    task automatic build_tables();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'b0000};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]}
                  ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
        rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                     8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    task automatic model_expand(input logic [255:0] k, input int nk);
        logic [31:0] t;
        ref_nr = nk + 6;
        for (int i = 0; i < nk; i++) ref_w[i] = k[255-32*i -: 32];
        for (int i = nk; i < 4 * (ref_nr + 1); i++) begin
            t = ref_w[i-1];
            if (i % nk == 0)
                t = subw({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk-1], 24'h0};
            else if (nk == 8 && i % 8 == 4)
                t = subw(t);
            ref_w[i] = ref_w[i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] exp_key(input int r, input bit dec);
        int e;
        if (r > ref_nr) return '0;
        e = dec ? ref_nr - r : r;
        return {ref_w[4*e], ref_w[4*e+1], ref_w[4*e+2], ref_w[4*e+3]};
    endfunction

    // Scoreboard
    typedef struct {
        int           due;
        logic [127:0] val;
        string        tag;
    } item_t;

    item_t sbq [$];

    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0 && sbq[0].due <= cyc) begin
                it = sbq.pop_front();
                chk(it.tag, rd_key, it.val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input bit d);
`ifdef KEYSCHED_DEC_ORDER_EN
        rd_dec = d;
`endif
    endtask

    function automatic bit rand_dec();
`ifdef KEYSCHED_DEC_ORDER_EN
        return bit'($urandom_range(0, 1));
`else
        return 1'b0;
`endif
    endfunction

    task automatic read_check(input int r, input bit dec,
                              input logic [127:0] exp, input string tag);
        rd_round = 4'(r);
        set_dec(dec);
        sbq.push_back('{cyc + 1, exp, tag});
        tick();
    endtask

    task automatic run_expand(input logic [1:0] ks, input logic [255:0] k,
                              input int lat_exp, input int inject_at,
                              input string tag);
        int lat;
        int nk;
        nk = (ks == 2'd0) ? 4 : (ks == 2'd1) ? 6 : 8;
        model_expand(k, nk);
        key = k;
        key_size = ks;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_rise"}, {126'd0, busy, ready}, {126'd0, 2'b10});
        lat = 0;
        while (lat < 200) begin
            rd_round = 4'($urandom_range(0, 15));
            set_dec(rand_dec());
            sbq.push_back('{cyc + 1, 128'd0, {tag, "_rd_busy"}});
            if (lat == inject_at) begin
                start = 1'b1;
                key_size = 2'($urandom_range(0, 2));
                key = {$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom};
            end
            tick();
            start = 1'b0;
            key = k;
            key_size = ks;
            lat++;
            if (ready) break;
        end
        chk({tag, "_latency"}, 128'(lat), 128'(lat_exp));
        chk({tag, "_rd_at_ready"}, rd_key, 128'd0);
    endtask

    localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K192 =
        192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [255:0] rk;
        logic [1:0]   rs;
        int           w;
        build_tables();
        rst = 1'b0;
        start = 1'b0;
        key_size = 2'd0;
        key = '0;
        rd_round = 4'd0;
        set_dec(1'b0);
        start4 = 1'b0;
        ks4 = 2'd0;
        key4 = K128;
        rr4 = 4'd0;
        repeat (3) tick();
        chk("reset_status", {126'd0, busy, ready}, 128'd0);
        chk("reset_rd_key", rd_key, 128'd0);
        rst = 1'b1;
        tick();

        key_size = 2'b11;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("invalid_idle", {126'd0, busy, ready}, 128'd0);

        run_expand(2'd0, {K128, 128'hdeadbeef_0badf00d_12345678_9abcdef0},
                   41, -1, "aes128");
        read_check(10, 1'b0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "v128_r10");
        read_check(0, 1'b0, K128, "v128_r0");
        read_check(11, 1'b0, 128'd0, "v128_r11");
        read_check(5, 1'b0, exp_key(5, 1'b0), "v128_r5");

        key_size = 2'b11;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("invalid_ready", {126'd0, busy, ready}, 128'd1);
        read_check(10, 1'b0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "v128_kept");

        run_expand(2'd1, {K192, 64'hffff0000_a5a5a5a5}, 47, -1, "aes192");
        read_check(12, 1'b0, 128'he98ba06f448c773c8ecc720401002202, "v192_r12");
        read_check(13, 1'b0, 128'd0, "v192_r13");

        run_expand(2'd2, K256, 53, -1, "aes256");
        read_check(14, 1'b0, 128'hfe4890d1e6188d0b046df344706c631e, "v256_r14");
`ifdef KEYSCHED_DEC_ORDER_EN
        read_check(0, 1'b1, 128'hfe4890d1e6188d0b046df344706c631e, "v256_dec0");
        read_check(14, 1'b1, K256[255:128], "v256_dec14");
        read_check(15, 1'b1, 128'd0, "v256_dec15");
`endif

        run_expand(2'd0, {K128, 128'd0}, 41, -1, "restart128");
        read_check(10, 1'b0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "rs128_r10");

        run_expand(2'd0, {K128, 128'd0}, 41, 7, "inject128");
        read_check(10, 1'b0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "inj128_r10");
        read_check(3, 1'b0, exp_key(3, 1'b0), "inj128_r3");

        rd_round = 4'd0;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_ready_key", rd_key, 128'd0);
        chk("rst_ready_status", {126'd0, busy, ready}, 128'd0);
        tick();
        rst = 1'b1;
        tick();

        key = {K128, 128'd0};
        key_size = 2'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_status", {126'd0, busy, ready}, 128'd0);
        chk("rst_mid_key", rd_key, 128'd0);
        tick();
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_mid_idle", {126'd0, busy, ready}, 128'd0);
        run_expand(2'd0, {K128, 128'd0}, 41, -1, "after_rst");
        read_check(10, 1'b0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "ar128_r10");

        ks4 = 2'b10;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        chk("nk4_reject", {126'd0, busy4, ready4}, 128'd0);
        ks4 = 2'b00;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        chk("nk4_accept", {126'd0, busy4, ready4}, 128'd2);
        w = 0;
        while (!ready4 && w < 200) begin
            tick();
            w++;
        end
        chk("nk4_latency", 128'(w), 128'd41);
        rr4 = 4'd10;
        tick();
        chk("nk4_r10", rk4, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        for (int n = 0; n < 8; n++) begin
            rs = 2'($urandom_range(0, 2));
            rk = {$urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom};
            run_expand(rs, rk, (rs == 2'd0) ? 41 : (rs == 2'd1) ? 47 : 53,
                       (n % 2 == 1) ? int'($urandom_range(0, 30)) : -1, "rand");
            for (int r = 0; r < 16; r++) begin
                bit d;
                d = rand_dec();
                read_check(r, d, exp_key(r, d), "rand_rd");
            end
        end

        repeat (3) tick();
        chk("scoreboard_drain", 128'(sbq.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
